// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC ownership, credit-limited in-order fetch, prefetch FIFO and redirect flush.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    input  logic        inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

    logic [31:0]        data_mem [FIFO_DEPTH];
    logic [31:0]        pc_mem   [FIFO_DEPTH];
    logic [31:0]        rpc_mem  [FIFO_DEPTH];

    logic               req_fire, rsp_fire, rsp_drop, push, pop;
    logic [CNT_W:0]     credit_used;

    assign credit_used    = {1'b0, cnt_q} + {1'b0, out_q};
    // Request valid is a function of registered state only.
    assign imem_req_valid = (state_q == S_RUN) && (credit_used < DEPTH_L);
    assign imem_req_addr  = fetch_pc_q;

    assign inst_valid = (cnt_q != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (out_q != '0);
    assign rsp_drop = rsp_fire && ((drop_q != '0) || redirect_valid);
    assign push     = rsp_fire && !rsp_drop;
    assign pop      = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        out_d      = out_q + {{(CNT_W-1){1'b0}}, req_fire} - {{(CNT_W-1){1'b0}}, rsp_fire};
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        pq_wr_d    = pq_wr_q + {{(PTR_W-1){1'b0}}, req_fire};
        pq_rd_d    = pq_rd_q + {{(PTR_W-1){1'b0}}, rsp_fire};
        wr_ptr_d   = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        // Everything still in flight after this cycle's updates becomes stale.
        if (redirect_valid) begin
            drop_d     = out_d;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            cnt_d      = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (redirect_valid && (drop_d != '0)) state_d = S_FLUSH;
            S_FLUSH: if (drop_d == '0) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pq_wr_q    <= pq_wr_d;
            pq_rd_q    <= pq_rd_d;
        end
    end

    // Storage arrays carry data only; validity is tracked by the reset counters above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            rpc_mem[pq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rpc_mem[pq_rd_q];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'h0;
            perf_flushed_q <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'h0, push};
            perf_flushed_q <= perf_flushed_q + {31'h0, rsp_drop}
                              + (redirect_valid ? 32'(cnt_q) : 32'h0);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order latency-programmable memory model.
// Perf counter checks are compiled when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
`endif
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rsp_cnt = 0;
    pend_t       pend[$];
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_data_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, then drive the memory model.
    task automatic step();
        logic        fire, popped, rsp;
        logic [31:0] fa, ppc, pd;
        fire   = imem_req_valid && imem_req_ready;
        fa     = imem_req_addr;
        popped = inst_valid && inst_ready && !redirect_valid;
        ppc    = inst_pc;
        pd     = inst_data;
        rsp    = imem_rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (!reset) begin
            if (fire) begin
                req_q.push_back(fa);
                pend.push_back('{fa, cyc + lat - 1});
            end
            if (popped) begin
                pop_pc_q.push_back(ppc);
                pop_data_q.push_back(pd);
            end
            if (rsp) rsp_cnt++;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        pop_pc_q.delete();
        pop_data_q.delete();
        rsp_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pend.delete();
        repeat (n) step();
        reset = 1'b0;
        pend.delete();
        imem_rsp_valid = 1'b0;
        clear_logs();
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int b;
        b = budget;
        while (pop_pc_q.size() < n && b > 0) begin
            step();
            b--;
        end
        chk(tag, 32'(pop_pc_q.size() >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Reset state and basic streaming with a 1-cycle memory
        lat = 1;
        reset = 1'b1;
        step(); step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        do_reset(0);
        step();
        chk("s1_c1_inst_valid", 32'(inst_valid), 32'd0);
        chk("s1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s1_c1_req_addr", imem_req_addr, 32'h0);
        step();
        chk("s1_c2_inst_valid", 32'(inst_valid), 32'd0);
        chk("s1_c2_req_addr", imem_req_addr, 32'h4);
        step();
        chk("s1_c3_inst_valid", 32'(inst_valid), 32'd1);
        chk("s1_c3_inst_pc", inst_pc, 32'h0);
        chk("s1_c3_inst_data", inst_data, memf(32'h0));
        chk("s1_c3_req_addr", imem_req_addr, 32'h8);
        step();
        chk("s1_c4_inst_pc", inst_pc, 32'h4);
        chk("s1_c4_inst_valid", 32'(inst_valid), 32'd1);
        step();
        chk("s1_c5_inst_pc", inst_pc, 32'h8);
        chk("s1_c5_inst_data", inst_data, memf(32'h8));

        // Decode stalled: credit limit stops fetch at four words
        inst_ready = 1'b0;
        do_reset(2);
        repeat (8) step();
        chk("s2_req_count", 32'(req_q.size()), 32'd4);
        chk("s2_last_req", req_q[req_q.size()-1], 32'hC);
        chk("s2_req_valid_low", 32'(imem_req_valid), 32'd0);
        chk("s2_head_held", inst_pc, 32'h0);
        inst_ready = 1'b1;
        wait_pops("s2_pop_budget", 4, 10);
        chk("s2_pop0", pop_pc_q[0], 32'h0);
        chk("s2_pop1", pop_pc_q[1], 32'h4);
        chk("s2_pop2", pop_pc_q[2], 32'h8);
        chk("s2_pop3", pop_pc_q[3], 32'hC);
        chk("s2_pop3_data", pop_data_q[3], memf(32'hC));
        begin
            int b;
            b = 10;
            while (req_q.size() < 5 && b > 0) begin step(); b--; end
        end
        chk("s2_resume_cnt", 32'(req_q.size() >= 5), 32'd1);
        chk("s2_resume_addr", req_q[4], 32'h10);

        // Redirect with two requests in flight on a 3-cycle memory
        lat = 3;
        inst_ready = 1'b1;
        do_reset(2);
        step(); step(); step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        imem_req_ready = 1'b1;
        chk("s3_flush_req_valid", 32'(imem_req_valid), 32'd0);
        chk("s3_flush_inst_valid", 32'(inst_valid), 32'd0);
        step();
        chk("s3_flush2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("s3_flush2_inst_valid", 32'(inst_valid), 32'd0);
        step();
        chk("s3_run_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s3_run_req_addr", imem_req_addr, 32'h100);
        chk("s3_run_inst_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("s6_perf_flushed", perf_flushed, 32'd2);
        chk("s6_perf_fetched0", perf_fetched, 32'd0);
`endif
        wait_pops("s3_pop_budget", 2, 20);
        chk("s3_pop0", pop_pc_q[0], 32'h100);
        chk("s3_pop0_data", pop_data_q[0], memf(32'h100));
        chk("s3_pop1", pop_pc_q[1], 32'h104);
`ifdef FETCH_PERF_CNT_EN
        chk("s6_perf_fetched", perf_fetched, 32'(rsp_cnt - 2));
        chk("s6_perf_flushed_hold", perf_flushed, 32'd2);
`endif

        // Redirect to an unaligned target while the FIFO holds three and a pop is offered
        lat = 1;
        inst_ready = 1'b0;
        do_reset(2);
        step(); step(); step(); step();
        imem_req_ready = 1'b0;
        step();
        chk("s4_pre_inst_valid", 32'(inst_valid), 32'd1);
        chk("s4_pre_inst_pc", inst_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        inst_ready     = 1'b1;
        step();
        chk("s4_flushed_valid", 32'(inst_valid), 32'd0);
        chk("s4_pop_ignored", 32'(pop_pc_q.size()), 32'd0);
        chk("s4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s4_req_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("s4_perf_flushed", perf_flushed, 32'd3);
`endif
        imem_req_ready = 1'b1;
        wait_pops("s4_pop_budget", 1, 10);
        chk("s4_pop0", pop_pc_q[0], 32'h100);
        chk("s4_pop0_data", pop_data_q[0], memf(32'h100));

        // Reset with a full FIFO, then a stale response while nothing is outstanding
        inst_ready = 1'b0;
        do_reset(2);
        repeat (8) step();
        chk("s5_full_valid", 32'(inst_valid), 32'd1);
        chk("s5_full_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        pend.delete();
        clear_logs();
        chk("s5_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("s5_rst_inst_pc", inst_pc, 32'h0);
        chk("s5_rst_req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        inst_ready     = 1'b1;
        step();
        chk("s5_stale_ignored", 32'(inst_valid), 32'd0);
        chk("s5_refetch_addr", imem_req_addr, 32'h0);
        wait_pops("s5_pop_budget", 2, 10);
        chk("s5_pop0", pop_pc_q[0], 32'h0);
        chk("s5_pop0_data", pop_data_q[0], memf(32'h0));
        chk("s5_pop1", pop_pc_q[1], 32'h4);

        // PC wrap at the top of the address space
        do_reset(2);
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        chk("s7_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("s7_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        wait_pops("s7_pop_budget", 2, 10);
        chk("s7_pop0", pop_pc_q[0], 32'hFFFF_FFFC);
        chk("s7_pop0_data", pop_data_q[0], memf(32'hFFFF_FFFC));
        chk("s7_pop1_wrap", pop_pc_q[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
